// File: rtl/sram_arb_if.sv
// Bundled signals of the two-port SRAM arbiter: CPU port, debug/loader port
// and the asynchronous SRAM bus.
interface sram_arb_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_done;
  logic [DW-1:0] cpu_rdata;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_done;
  logic [DW-1:0] dbg_rdata;

  logic          cen;
  logic          oen;
  logic          wen;
  logic          den;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic [DW-1:0] din;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_done, dbg_rdata,
    output cen, oen, wen, den, addr, dout,
    input  din
  );

  // Requester / SRAM model side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_done, dbg_rdata,
    input  cen, oen, wen, den, addr, dout,
    output din
  );
endinterface

// File: rtl/sram_arb.sv
// Round-robin arbiter between a CPU port and a debug/loader port sharing one
// asynchronous SRAM; every access is a fixed IDLE/SETUP/STROBE/HOLD sequence.
module sram_arb #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic        clk,
  input  logic        rst,
  sram_arb_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state, state_nxt;
  logic          we_l, we_nxt;
  logic          own_dbg, own_nxt;
  logic          last_dbg, last_nxt;
  logic          win_dbg;

  logic          cen_q, oen_q, wen_q, den_q;
  logic          cen_nxt, oen_nxt, wen_nxt, den_nxt;
  logic          cpu_gnt_q, dbg_gnt_q, cpu_done_q, dbg_done_q;
  logic          cpu_gnt_nxt, dbg_gnt_nxt, cpu_done_nxt, dbg_done_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic [DW-1:0] dout_q, dout_nxt;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_nxt;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_nxt;

  // Debug wins when it is the only requester, or on a tie when CPU went last.
  assign win_dbg = bus.dbg_req & (~bus.cpu_req | ~last_dbg);

  // Outputs are computed for the state being entered, then registered, so
  // each SRAM strobe level lines up with the cycle of the state it belongs to.
  always_comb begin
    state_nxt     = state;
    we_nxt        = we_l;
    own_nxt       = own_dbg;
    last_nxt      = last_dbg;
    cen_nxt       = 1'b1;
    oen_nxt       = 1'b1;
    wen_nxt       = 1'b1;
    den_nxt       = 1'b0;
    cpu_gnt_nxt   = 1'b0;
    dbg_gnt_nxt   = 1'b0;
    cpu_done_nxt  = 1'b0;
    dbg_done_nxt  = 1'b0;
    addr_nxt      = addr_q;
    dout_nxt      = dout_q;
    cpu_rdata_nxt = cpu_rdata_q;
    dbg_rdata_nxt = dbg_rdata_q;

    unique case (state)
      IDLE: begin
        if (bus.cpu_req || bus.dbg_req) begin
          state_nxt   = SETUP;
          own_nxt     = win_dbg;
          last_nxt    = win_dbg;
          we_nxt      = win_dbg ? bus.dbg_we   : bus.cpu_we;
          addr_nxt    = win_dbg ? bus.dbg_addr : bus.cpu_addr;
          if (we_nxt)
            dout_nxt  = win_dbg ? bus.dbg_wdata : bus.cpu_wdata;
          cen_nxt     = 1'b0;
          oen_nxt     = we_nxt;
          den_nxt     = we_nxt;
          cpu_gnt_nxt = ~win_dbg;
          dbg_gnt_nxt = win_dbg;
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        cen_nxt   = 1'b0;
        oen_nxt   = we_l;
        den_nxt   = we_l;
        wen_nxt   = ~we_l;
      end
      STROBE: begin
        state_nxt    = HOLD;
        den_nxt      = we_l;
        cpu_done_nxt = ~own_dbg;
        dbg_done_nxt = own_dbg;
        if (!we_l) begin
          if (own_dbg) dbg_rdata_nxt = bus.din;
          else         cpu_rdata_nxt = bus.din;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_l      <= 1'b0;
      own_dbg   <= 1'b0;
      last_dbg  <= 1'b1;
      cen_q     <= 1'b1;
      oen_q     <= 1'b1;
      wen_q     <= 1'b1;
      den_q     <= 1'b0;
      cpu_gnt_q <= 1'b0;
      dbg_gnt_q <= 1'b0;
      cpu_done_q <= 1'b0;
      dbg_done_q <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state     <= state_nxt;
      we_l      <= we_nxt;
      own_dbg   <= own_nxt;
      last_dbg  <= last_nxt;
      cen_q     <= cen_nxt;
      oen_q     <= oen_nxt;
      wen_q     <= wen_nxt;
      den_q     <= den_nxt;
      cpu_gnt_q <= cpu_gnt_nxt;
      dbg_gnt_q <= dbg_gnt_nxt;
      cpu_done_q <= cpu_done_nxt;
      dbg_done_q <= dbg_done_nxt;
      addr_q    <= addr_nxt;
      dout_q    <= dout_nxt;
      cpu_rdata_q <= cpu_rdata_nxt;
      dbg_rdata_q <= dbg_rdata_nxt;
    end
  end

  assign bus.cen       = cen_q;
  assign bus.oen       = oen_q;
  assign bus.wen       = wen_q;
  assign bus.den       = den_q;
  assign bus.addr      = addr_q;
  assign bus.dout      = dout_q;
  assign bus.cpu_gnt   = cpu_gnt_q;
  assign bus.dbg_gnt   = dbg_gnt_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.dbg_done  = dbg_done_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb: single reads/writes, round-robin ties,
// mid-access reset and a random-traffic protocol sweep.
module tb_sram_arb;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_cg = 0, n_cd = 0, n_dg = 0, n_dd = 0;

  sram_arb_if #(.AW(8), .DW(8)) bus ();

  sram_arb #(.AW(8), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_cen"}, 32'(bus.cen), 1);
    chk({tag, "_oen"}, 32'(bus.oen), 1);
    chk({tag, "_wen"}, 32'(bus.wen), 1);
    chk({tag, "_den"}, 32'(bus.den), 0);
  endtask

  // Per-cycle protocol invariants plus grant/done bookkeeping.
  task automatic monitor();
    chk("proto_wen_oen", 32'(!(bus.wen == 1'b0 && bus.oen == 1'b0)), 1);
    chk("proto_den_oen", 32'(!(bus.den == 1'b1 && bus.oen == 1'b0)), 1);
    chk("proto_gnt_excl", 32'(!(bus.cpu_gnt && bus.dbg_gnt)), 1);
    if (bus.cpu_gnt)  n_cg++;
    if (bus.dbg_gnt)  n_dg++;
    if (bus.cpu_done) n_cd++;
    if (bus.dbg_done) n_dd++;
  endtask

  initial begin
    rst = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    bus.din = '0;
    tick();
    tick();

    // Reset state
    chk_idle_bus("rst");
    chk("rst_addr", 32'(bus.addr), 0);
    chk("rst_dout", 32'(bus.dout), 0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 0);
    chk("rst_dbg_rdata", 32'(bus.dbg_rdata), 0);
    chk("rst_gnt", 32'({bus.cpu_gnt, bus.dbg_gnt, bus.cpu_done, bus.dbg_done}), 0);

    // CPU read alone
    rst = 1'b0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h12;
    tick();
    chk("rd_setup_cpu_gnt", 32'(bus.cpu_gnt), 1);
    chk("rd_setup_dbg_gnt", 32'(bus.dbg_gnt), 0);
    chk("rd_setup_cen", 32'(bus.cen), 0);
    chk("rd_setup_oen", 32'(bus.oen), 0);
    chk("rd_setup_den", 32'(bus.den), 0);
    chk("rd_setup_addr", 32'(bus.addr), 'h12);
    bus.cpu_req = 0; bus.cpu_addr = 8'hEE;
    bus.din = 8'hA5;
    tick();
    chk("rd_strobe_gnt", 32'(bus.cpu_gnt), 0);
    chk("rd_strobe_cen", 32'(bus.cen), 0);
    chk("rd_strobe_oen", 32'(bus.oen), 0);
    chk("rd_strobe_wen", 32'(bus.wen), 1);
    chk("rd_strobe_addr", 32'(bus.addr), 'h12);
    tick();
    bus.din = 8'h00;
    chk("rd_hold_done", 32'(bus.cpu_done), 1);
    chk("rd_hold_dbg_done", 32'(bus.dbg_done), 0);
    chk("rd_hold_cen", 32'(bus.cen), 1);
    chk("rd_hold_oen", 32'(bus.oen), 1);
    chk("rd_cpu_rdata", 32'(bus.cpu_rdata), 'hA5);
    chk("rd_dbg_rdata", 32'(bus.dbg_rdata), 0);
    tick();
    chk("rd_idle_done", 32'(bus.cpu_done), 0);
    chk("rd_idle_rdata_held", 32'(bus.cpu_rdata), 'hA5);
    chk_idle_bus("rd_idle");

    // Debug write alone; address changes after grant must be ignored
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 8'h40; bus.dbg_wdata = 8'h3C;
    tick();
    chk("wr_setup_dbg_gnt", 32'(bus.dbg_gnt), 1);
    chk("wr_setup_cpu_gnt", 32'(bus.cpu_gnt), 0);
    chk("wr_setup_cen", 32'(bus.cen), 0);
    chk("wr_setup_den", 32'(bus.den), 1);
    chk("wr_setup_oen", 32'(bus.oen), 1);
    chk("wr_setup_wen", 32'(bus.wen), 1);
    chk("wr_setup_addr", 32'(bus.addr), 'h40);
    chk("wr_setup_dout", 32'(bus.dout), 'h3C);
    bus.dbg_req = 0; bus.dbg_addr = 8'h77; bus.dbg_wdata = 8'h11;
    tick();
    chk("wr_strobe_wen", 32'(bus.wen), 0);
    chk("wr_strobe_den", 32'(bus.den), 1);
    chk("wr_strobe_oen", 32'(bus.oen), 1);
    chk("wr_strobe_cen", 32'(bus.cen), 0);
    chk("wr_strobe_addr", 32'(bus.addr), 'h40);
    tick();
    chk("wr_hold_done", 32'(bus.dbg_done), 1);
    chk("wr_hold_den", 32'(bus.den), 1);
    chk("wr_hold_wen", 32'(bus.wen), 1);
    chk("wr_hold_cen", 32'(bus.cen), 1);
    chk("wr_hold_oen", 32'(bus.oen), 1);
    chk("wr_hold_addr", 32'(bus.addr), 'h40);
    chk("wr_hold_dout", 32'(bus.dout), 'h3C);
    chk("wr_dbg_rdata", 32'(bus.dbg_rdata), 0);
    chk("wr_cpu_rdata", 32'(bus.cpu_rdata), 'hA5);
    tick();
    chk_idle_bus("wr_idle");
    chk("wr_idle_addr_held", 32'(bus.addr), 'h40);
    chk("wr_idle_dout_held", 32'(bus.dout), 'h3C);

    // Both requesters held: grants alternate CPU, DBG, CPU, DBG
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 8'h21;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 8'h31;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_cpu_gnt", 32'(bus.cpu_gnt), 32'(i % 2 == 0));
      chk("rr_dbg_gnt", 32'(bus.dbg_gnt), 32'(i % 2 == 1));
      chk("rr_addr", 32'(bus.addr), (i % 2 == 0) ? 'h21 : 'h31);
      bus.din = 8'(8'h50 + i);
      tick();
      chk("rr_no_regrant", 32'({bus.cpu_gnt, bus.dbg_gnt}), 0);
      tick();
      chk("rr_cpu_done", 32'(bus.cpu_done), 32'(i % 2 == 0));
      chk("rr_dbg_done", 32'(bus.dbg_done), 32'(i % 2 == 1));
      tick();
    end
    chk("rr_cpu_rdata", 32'(bus.cpu_rdata), 'h52);
    chk("rr_dbg_rdata", 32'(bus.dbg_rdata), 'h53);
    bus.cpu_req = 0; bus.dbg_req = 0;

    // Reset during STROBE of a CPU write aborts it
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 8'h55; bus.cpu_wdata = 8'h99;
    tick();
    chk("ab_setup_gnt", 32'(bus.cpu_gnt), 1);
    bus.cpu_req = 0;
    tick();
    chk("ab_strobe_wen", 32'(bus.wen), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_bus("ab_rst");
    chk("ab_rst_done", 32'({bus.cpu_done, bus.dbg_done}), 0);
    chk("ab_rst_addr", 32'(bus.addr), 0);
    chk("ab_rst_dout", 32'(bus.dout), 0);
    chk("ab_rst_rdata", 32'({bus.cpu_rdata, bus.dbg_rdata}), 0);
    tick();
    chk("ab_after_done", 32'({bus.cpu_done, bus.dbg_done}), 0);
    chk_idle_bus("ab_after");
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 8'h0F; bus.din = 8'hC3;
    tick();
    chk("ab_new_gnt", 32'(bus.dbg_gnt), 1);
    chk("ab_new_addr", 32'(bus.addr), 'h0F);
    bus.dbg_req = 0;
    tick();
    tick();
    chk("ab_new_done", 32'(bus.dbg_done), 1);
    chk("ab_new_rdata", 32'(bus.dbg_rdata), 'hC3);
    chk("ab_new_cpu_rdata", 32'(bus.cpu_rdata), 0);
    tick();

    // Random traffic protocol sweep
    for (int c = 0; c < 400; c++) begin
      if (!bus.cpu_req && $urandom_range(0, 2) == 0) begin
        bus.cpu_req = 1; bus.cpu_we = 1'($urandom);
        bus.cpu_addr = 8'($urandom); bus.cpu_wdata = 8'($urandom);
      end
      if (!bus.dbg_req && $urandom_range(0, 2) == 0) begin
        bus.dbg_req = 1; bus.dbg_we = 1'($urandom);
        bus.dbg_addr = 8'($urandom); bus.dbg_wdata = 8'($urandom);
      end
      bus.din = 8'($urandom);
      tick();
      monitor();
      if (bus.cpu_gnt) bus.cpu_req = 0;
      if (bus.dbg_gnt) bus.dbg_req = 0;
    end
    bus.cpu_req = 0; bus.dbg_req = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      monitor();
    end
    chk("rand_cpu_gnt_seen", 32'(n_cg > 0), 1);
    chk("rand_dbg_gnt_seen", 32'(n_dg > 0), 1);
    chk("rand_cpu_done_per_gnt", 32'(n_cd), 32'(n_cg));
    chk("rand_dbg_done_per_gnt", 32'(n_dd), 32'(n_dg));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
